// File: rtl/access_pkg.sv
// Shared types and default mapping parameters for the access responder.
// Mapping under check: resource = (user * MULT) % MOD.
package access_pkg;

  localparam int ID_W_DEF = 4;
  localparam int MULT_DEF = 3;
  localparam int MOD_DEF  = 10;

  typedef enum logic [1:0] {
    RSN_OK       = 2'd0,
    RSN_MISMATCH = 2'd1,
    RSN_RANGE    = 2'd2,
    RSN_LOCKED   = 2'd3
  } rsp_reason_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/access_lock_tracker.sv
// Per-user consecutive-deny counters and the single-user lockout timer.
// A user reaching the deny limit becomes the locked user; a newer lock replaces an older one.
module access_lock_tracker
  import access_pkg::*;
#(
  parameter int ID_W        = ID_W_DEF,
  parameter int DENY_LIMIT  = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            chk,
  input  logic [ID_W-1:0] user,
  input  logic            deny,
  input  logic            grant,
  input  logic            locked,
  output logic            lock_active,
  output logic [ID_W-1:0] lock_user
);

  localparam int USERS  = 1 << ID_W;
  localparam int DCNT_W = $clog2(DENY_LIMIT + 1);
  localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);

  logic [DCNT_W-1:0] deny_cnt [USERS];
  logic [DCNT_W-1:0] cnt_inc;
  logic [TMR_W-1:0]  timer;
  logic              hit_limit;

  assign cnt_inc   = deny_cnt[user] + 1'b1;
  // A LOCKED check never reaches here as a deny, so the count is left alone.
  assign hit_limit = chk && deny && !locked && (cnt_inc >= DCNT_W'(DENY_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < USERS; i++) deny_cnt[i] <= '0;
    end else if (chk && !locked) begin
      if (grant || hit_limit)
        deny_cnt[user] <= '0;
      else if (deny)
        deny_cnt[user] <= cnt_inc;
    end
  end

  // Timer runs free of the FSM; lock drops on the edge where it steps 1 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_active <= 1'b0;
      lock_user   <= '0;
      timer       <= '0;
    end else if (hit_limit) begin
      lock_active <= 1'b1;
      lock_user   <= user;
      timer       <= TMR_W'(LOCK_CYCLES);
    end else if (timer != '0) begin
      timer <= timer - 1'b1;
      if (timer == TMR_W'(1)) lock_active <= 1'b0;
    end
  end

endmodule

// File: rtl/access_responder.sv
// Resource-side responder: checks (user, resource) requests against the mapping and answers grant/deny.
// Optional ACCESS_RESP_STATS_EN adds saturating grant/deny handshake counters.
module access_responder
  import access_pkg::*;
#(
  parameter int ID_W        = ID_W_DEF,
  parameter int MULT        = MULT_DEF,
  parameter int MOD         = MOD_DEF,
  parameter int DENY_LIMIT  = 3,
  parameter int LOCK_CYCLES = 16
`ifdef ACCESS_RESP_STATS_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_user_id,
  input  logic [ID_W-1:0] req_resource_id,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_grant,
  output logic [1:0]      rsp_reason,
  output logic [ID_W-1:0] rsp_user_id,
  output logic [ID_W-1:0] rsp_resource_id,
  output logic            lock_active,
  output logic [ID_W-1:0] lock_user
`ifdef ACCESS_RESP_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt,
  output logic [CNT_W-1:0] deny_cnt
`endif
);

  localparam int PROD_W = ID_W + 2;

  state_e          state, state_next;
  logic [ID_W-1:0] user_q, res_q;
  rsp_reason_e     reason_q, reason;
  logic [PROD_W-1:0] expected;
  logic            locked, out_range, mismatch, grant, deny, chk;

  assign req_ready       = (state == IDLE);
  assign rsp_valid       = (state == RESP);
  assign rsp_reason      = reason_q;
  assign rsp_user_id     = user_q;
  assign rsp_resource_id = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = CHECK;
      CHECK:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Check stage: mapping evaluated at full width so user*MULT cannot wrap before the mod.
  always_comb begin
    expected  = (PROD_W'(user_q) * PROD_W'(MULT)) % PROD_W'(MOD);
    chk       = (state == CHECK);
    locked    = lock_active && (user_q == lock_user);
    out_range = PROD_W'(res_q) >= PROD_W'(MOD);
    mismatch  = PROD_W'(res_q) != expected;
    reason    = RSN_OK;
    if (locked)         reason = RSN_LOCKED;
    else if (out_range) reason = RSN_RANGE;
    else if (mismatch)  reason = RSN_MISMATCH;
    grant     = (reason == RSN_OK);
    deny      = (reason == RSN_RANGE) || (reason == RSN_MISMATCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      user_q    <= '0;
      res_q     <= '0;
      rsp_grant <= 1'b0;
      reason_q  <= RSN_OK;
    end else begin
      if (state == IDLE && req_valid) begin
        user_q <= req_user_id;
        res_q  <= req_resource_id;
      end
      if (chk) begin
        rsp_grant <= grant;
        reason_q  <= reason;
      end
    end
  end

  access_lock_tracker #(
    .ID_W        (ID_W),
    .DENY_LIMIT  (DENY_LIMIT),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock (
    .clk         (clk),
    .rst_n       (rst_n),
    .chk         (chk),
    .user        (user_q),
    .deny        (deny),
    .grant       (grant),
    .locked      (locked),
    .lock_active (lock_active),
    .lock_user   (lock_user)
  );

`ifdef ACCESS_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      deny_cnt  <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_grant) begin
        if (grant_cnt != '1) grant_cnt <= grant_cnt + 1'b1;
      end else begin
        if (deny_cnt != '1) deny_cnt <= deny_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
